// File: rtl/bf_pipe_dual.sv
// bf_pipe_dual: 3-stage pipelined modular butterfly for NTT (CT) / INTT (GS).
// The mode bit is sampled per beat and travels with it, so CT and GS beats
// can be interleaved freely. Whole-pipe backpressure: a held result freezes
// every stage.
// Optional feature macro: BF_HALF_SCALE_EN. When it is defined, GS results are
// multiplied by 2^-1 mod q before the output register.
module bf_pipe_dual #(
   parameter int BIT_LEN  = 13,
   parameter int q        = 7681,
   parameter int PROD_LEN = 2*BIT_LEN
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic                mode,
   input  logic [BIT_LEN-1:0]  in0,
   input  logic [BIT_LEN-1:0]  in1,
   input  logic [BIT_LEN-1:0]  phi,
   output logic                out_valid,
   input  logic                out_ready,
   output logic [BIT_LEN-1:0]  out0,
   output logic [BIT_LEN-1:0]  out1,
   output logic [1:0]          inflight
);

   localparam logic [BIT_LEN-1:0]  Q_B = BIT_LEN'(q);
   localparam logic [BIT_LEN:0]    Q_E = (BIT_LEN+1)'(q);
   localparam logic [PROD_LEN-1:0] Q_P = PROD_LEN'(q);

   // (x + y) mod q for x, y already in [0, q-1]
   function automatic logic [BIT_LEN-1:0] mod_add(input logic [BIT_LEN-1:0] x,
                                                  input logic [BIT_LEN-1:0] y);
      logic [BIT_LEN:0] s;
      s = {1'b0, x} + {1'b0, y};
      if (s >= Q_E) s = s - Q_E;
      return BIT_LEN'(s);
   endfunction

   // (x - y) mod q for x, y already in [0, q-1]; wraps by adding q
   function automatic logic [BIT_LEN-1:0] mod_sub(input logic [BIT_LEN-1:0] x,
                                                  input logic [BIT_LEN-1:0] y);
      if (x >= y) return x - y;
      return BIT_LEN'({1'b0, x} + Q_E - {1'b0, y});
   endfunction

`ifdef BF_HALF_SCALE_EN
   // x * 2^-1 mod q: an odd x becomes even after adding the odd modulus q
   function automatic logic [BIT_LEN-1:0] half_mod(input logic [BIT_LEN-1:0] x);
      logic [BIT_LEN:0] t;
      t = x[0] ? ({1'b0, x} + Q_E) : {1'b0, x};
      return BIT_LEN'(t >> 1);
   endfunction
`endif

   // pipeline control state
   logic                r_v1, r_v2, r_v3;
   logic [1:0]          r_inflight;

   // S1 operand register
   logic                r_s1_mode;
   logic [BIT_LEN-1:0]  r_s1_op0;
   logic [PROD_LEN-1:0] r_s1_op1;
   logic [BIT_LEN-1:0]  r_s1_w;

   // S2 reduction register
   logic                r_s2_mode;
   logic [BIT_LEN-1:0]  r_s2_op0;
   logic [BIT_LEN-1:0]  r_s2_p;

   // S3 output register
   logic [BIT_LEN-1:0]  r_out0, r_out1;

   logic                w_stall, w_accept, w_consume;
   logic [BIT_LEN-1:0]  w_a, w_b, w_w;
   logic [PROD_LEN-1:0] w_ct_prod, w_gs_prod;
   logic [BIT_LEN-1:0]  w_s1_op0_next;
   logic [PROD_LEN-1:0] w_s1_op1_next;
   logic [BIT_LEN-1:0]  w_s2_p_next;
   logic [BIT_LEN-1:0]  w_ct_out0, w_ct_out1, w_gs_out0, w_gs_out1;
   logic [BIT_LEN-1:0]  w_out0_next, w_out1_next;

   assign w_stall   = r_v3 && !out_ready;
   assign in_ready  = !w_stall;
   assign w_accept  = in_valid && in_ready;
   assign w_consume = r_v3 && out_ready;

   assign out_valid = r_v3;
   assign out0      = r_out0;
   assign out1      = r_out1;
   assign inflight  = r_inflight;

   // capture: fold out-of-range operands back into [0, q-1]
   assign w_a = in0 % Q_B;
   assign w_b = in1 % Q_B;
   assign w_w = phi % Q_B;

   // S1 next: CT keeps a and the raw product; GS forms the sum and difference
   assign w_ct_prod     = PROD_LEN'(w_b) * PROD_LEN'(w_w);
   assign w_s1_op0_next = mode ? mod_add(w_a, w_b) : w_a;
   assign w_s1_op1_next = mode ? PROD_LEN'(mod_sub(w_a, w_b)) : w_ct_prod;

   // S2 next: CT reduces b*w; GS multiplies the difference by w, then reduces
   assign w_gs_prod   = PROD_LEN'(r_s1_op1[BIT_LEN-1:0]) * PROD_LEN'(r_s1_w);
   assign w_s2_p_next = BIT_LEN'((r_s2_sel_gs() ? w_gs_prod : r_s1_op1) % Q_P);

   function automatic logic r_s2_sel_gs();
      return r_s1_mode;
   endfunction

   // S3 next: CT combines a with p; GS passes the sum and the reduced product
   assign w_ct_out0 = mod_add(r_s2_op0, r_s2_p);
   assign w_ct_out1 = mod_sub(r_s2_op0, r_s2_p);
`ifdef BF_HALF_SCALE_EN
   assign w_gs_out0 = half_mod(r_s2_op0);
   assign w_gs_out1 = half_mod(r_s2_p);
`else
   assign w_gs_out0 = r_s2_op0;
   assign w_gs_out1 = r_s2_p;
`endif
   assign w_out0_next = r_s2_mode ? w_gs_out0 : w_ct_out0;
   assign w_out1_next = r_s2_mode ? w_gs_out1 : w_ct_out1;

   // stage valid bits and beat count; whole pipe advances unless stalled
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_v1       <= 1'b0;
         r_v2       <= 1'b0;
         r_v3       <= 1'b0;
         r_inflight <= 2'd0;
      end else begin
         if (!w_stall) begin
            r_v1 <= w_accept;
            r_v2 <= r_v1;
            r_v3 <= r_v2;
         end
         unique case ({w_accept, w_consume})
            2'b10:   r_inflight <= r_inflight + 2'd1;
            2'b01:   r_inflight <= r_inflight - 2'd1;
            default: r_inflight <= r_inflight;
         endcase
      end
   end

   // S1/S2 data registers; only loaded by a real beat so bubbles cost no toggles
   always_ff @(posedge clk) begin
      if (w_accept) begin
         r_s1_mode <= mode;
         r_s1_op0  <= w_s1_op0_next;
         r_s1_op1  <= w_s1_op1_next;
         r_s1_w    <= w_w;
      end
      if (!w_stall && r_v1) begin
         r_s2_mode <= r_s1_mode;
         r_s2_op0  <= r_s1_op0;
         r_s2_p    <= w_s2_p_next;
      end
   end

   // output register; holds the last result while S3 is empty
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_out0 <= '0;
         r_out1 <= '0;
      end else if (!w_stall && r_v2) begin
         r_out0 <= w_out0_next;
         r_out1 <= w_out1_next;
      end
   end

endmodule
